// File: rtl/multiport_banked_ram_pkg.sv
// Processor-wide memory constants, controller state encoding and a
// constant-evaluable clog2 for sizing derived widths.
package multiport_banked_ram_pkg;

  localparam int DEF_MEM_WIDTH = 12;
  localparam int DEF_MEM_SIZE  = 4096;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one bank: the first requester at or after the
// pointer wins; the pointer moves past the winner and holds when idle.
module rr_arbiter
  import multiport_banked_ram_pkg::*;
#(
  parameter int port_count = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [port_count-1:0] i_req,
  output logic [port_count-1:0] o_gnt
);

  localparam int PW = (clog2(port_count) > 0) ? clog2(port_count) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_gnt     = '0;
    w_ptr_nxt = r_ptr;
    w_idx     = '0;
    w_found   = 1'b0;
    for (int i = 0; i < port_count; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % port_count);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
        w_ptr_nxt    = PW'((int'(w_idx) + 1) % port_count);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_ptr <= '0;
    else       r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/multiport_banked_ram.sv
// N-port shared RAM split into address-interleaved banks, each with its own
// round-robin arbiter; zero-fills every bank after reset before raising ready.
module multiport_banked_ram
  import multiport_banked_ram_pkg::*;
#(
  parameter int mem_size   = DEF_MEM_SIZE,
  parameter int mem_width  = DEF_MEM_WIDTH,
  parameter int port_count = 2,
  parameter int bank_count = 4,
  parameter int addr_width = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [port_count-1:0]            req,
  input  logic [port_count-1:0]            wr,
  input  logic [port_count*addr_width-1:0] address,
  input  logic [port_count*mem_width-1:0]  datain,
  output logic [port_count-1:0]            gnt,
  output logic [port_count*mem_width-1:0]  dataout,
  output logic [port_count-1:0]            rvalid,
  output logic                             ready
);

  localparam int ROWS      = mem_size / bank_count;
  localparam int BANK_BITS = clog2(bank_count);
  localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W     = (clog2(ROWS) > 0) ? clog2(ROWS) : 1;

  logic                  r_state;
  logic                  w_state_nxt;
  logic [ROW_W-1:0]      r_fill_cnt;
  logic                  w_fill_last;
  logic                  w_fill_we;

  logic [BW-1:0]         w_bank_of  [port_count];
  logic [ROW_W-1:0]      w_row_of   [port_count];
  logic [port_count-1:0] w_bank_gnt [bank_count];
  logic [mem_width-1:0]  w_bank_rd  [bank_count];

  logic [port_count-1:0] r_rvalid;
  logic [mem_width-1:0]  r_dout     [port_count];

  assign w_fill_last = (r_fill_cnt == ROW_W'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && w_fill_last) w_state_nxt = ST_RUN;
  end

  always_comb begin
    ready     = (r_state == ST_RUN);
    w_fill_we = (r_state == ST_INIT) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset)                    r_fill_cnt <= '0;
    else if (r_state == ST_INIT)  r_fill_cnt <= r_fill_cnt + 1'b1;
  end

  // Low address bits pick the bank so consecutive words spread across banks.
  for (genvar p = 0; p < port_count; p++) begin : g_port
    logic [addr_width-1:0] w_addr;
    assign w_addr       = address[p*addr_width +: addr_width];
    assign w_bank_of[p] = BW'(w_addr & addr_width'(bank_count - 1));
    assign w_row_of[p]  = ROW_W'(w_addr >> BANK_BITS);
    assign dataout[p*mem_width +: mem_width] = r_dout[p];
  end

  for (genvar b = 0; b < bank_count; b++) begin : g_bank
    logic [mem_width-1:0]  r_mem [ROWS];
    logic [port_count-1:0] w_req;
    logic [port_count-1:0] w_gnt;
    logic [ROW_W-1:0]      w_row;
    logic                  w_we;
    logic [mem_width-1:0]  w_dat;

    always_comb begin
      w_req = '0;
      for (int p = 0; p < port_count; p++) begin
        w_req[p] = req[p] && ready && (w_bank_of[p] == BW'(b));
      end
    end

    rr_arbiter #(.port_count(port_count)) u_arb (
      .clk   (clk),
      .reset (reset),
      .i_req (w_req),
      .o_gnt (w_gnt)
    );

    // At most one grant per bank, so this mux selects the single owner.
    always_comb begin
      w_row = '0;
      w_we  = 1'b0;
      w_dat = '0;
      for (int p = 0; p < port_count; p++) begin
        if (w_gnt[p]) begin
          w_row = w_row_of[p];
          w_we  = wr[p] && !reset;
          w_dat = datain[p*mem_width +: mem_width];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (w_fill_we)  r_mem[r_fill_cnt] <= '0;
      else if (w_we)  r_mem[w_row]      <= w_dat;
    end

    assign w_bank_gnt[b] = w_gnt;
    assign w_bank_rd[b]  = r_mem[w_row];
  end

  always_comb begin
    gnt = '0;
    for (int b = 0; b < bank_count; b++) gnt = gnt | w_bank_gnt[b];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= '0;
      for (int p = 0; p < port_count; p++) r_dout[p] <= '0;
    end else begin
      for (int p = 0; p < port_count; p++) begin
        r_rvalid[p] <= gnt[p] && !wr[p];
        if (gnt[p] && !wr[p]) r_dout[p] <= w_bank_rd[w_bank_of[p]];
      end
    end
  end

  assign rvalid = r_rvalid;

endmodule

// File: tb/tb_multiport_banked_ram.sv
// Directed bench: read expectations go into a scoreboard queue with their due
// cycle; a negedge monitor pops and compares whenever rvalid is presented.
module tb_multiport_banked_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, wr, gnt, rvalid;
  logic [23:0] address, datain, dataout;
  logic        ready;

  logic [3:0]  req2, wr2, gnt2, rvalid2;
  logic [31:0] address2;
  logic [47:0] datain2, dataout2;
  logic        ready2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         port;
    logic [11:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiport_banked_ram dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .address(address),
    .datain(datain), .gnt(gnt), .dataout(dataout), .rvalid(rvalid), .ready(ready)
  );

  multiport_banked_ram #(
    .mem_size(256), .mem_width(12), .port_count(4), .bank_count(8), .addr_width(8)
  ) dut2 (
    .clk(clk), .reset(reset), .req(req2), .wr(wr2), .address(address2),
    .datain(datain2), .gnt(gnt2), .dataout(dataout2), .rvalid(rvalid2), .ready(ready2)
  );

  // Monitor: every rvalid must match the oldest expectation due this cycle.
  always @(negedge clk) begin
    logic [1:0]  m;
    logic [11:0] ed [2];
    exp_t        e;
    m = 2'b00;
    ed[0] = '0;
    ed[1] = '0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        checks++; errors++;
        $display("FAIL read_missed port=%0d got=none exp=%h", e.port, e.data);
      end else begin
        m[e.port]  = 1'b1;
        ed[e.port] = e.data;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (m[p]) begin
        checks++;
        if (rvalid[p] !== 1'b1 || dataout[p*12 +: 12] !== ed[p]) begin
          errors++;
          $display("FAIL read_data port=%0d cyc=%0d got rvalid=%b data=%h exp data=%h",
                   p, cyc, rvalid[p], dataout[p*12 +: 12], ed[p]);
        end
      end else if (rvalid[p] !== 1'b0) begin
        checks++; errors++;
        $display("FAIL unexpected_rvalid port=%0d cyc=%0d got=%b exp=0", p, cyc, rvalid[p]);
      end
    end
  end

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] rq, input logic [1:0] w,
                      input logic [11:0] a0, input logic [11:0] a1,
                      input logic [11:0] d0, input logic [11:0] d1,
                      input logic [1:0] eg, input logic [11:0] e0, input logic [11:0] e1);
    @(negedge clk);
    req = rq; wr = w; address = {a1, a0}; datain = {d1, d0};
    #1;
    chk("gnt", 48'(gnt), 48'(eg));
    if (eg[0] && !w[0]) sb.push_back('{0, e0, cyc + 1});
    if (eg[1] && !w[1]) sb.push_back('{1, e1, cyc + 1});
  endtask

  task automatic do_init();
    int n, n2;
    bit gbad;
    @(negedge clk);
    reset = 1'b1; req = '0; wr = '0; req2 = '0;
    @(posedge clk); #1;
    chk("rst_ready", 48'(ready), 48'd0);
    chk("rst_gnt", 48'(gnt), 48'd0);
    chk("rst_rvalid", 48'(rvalid), 48'd0);
    chk("rst_dataout", 48'(dataout), 48'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req = 2'b11; wr = 2'b00; address = {12'h011, 12'h7FF};
    n = 0; n2 = 0; gbad = 0;
    while (!ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (ready2 && n2 == 0) n2 = n;
      if (!ready && gnt !== 2'b00) gbad = 1;
    end
    req = 2'b00;
    chk("init_ready_latency", 48'(n), 48'd1024);
    chk("init_ready2_latency", 48'(n2), 48'd32);
    chk("init_gnt_blocked", 48'(gbad), 48'd0);
  endtask

  initial begin
    int cnt [4];
    reset = 1'b1; req = '0; wr = '0; address = '0; datain = '0;
    req2 = '0; wr2 = '0; address2 = '0; datain2 = '0;

    do_init();

    // Read of a freshly filled word.
    step(2'b01, 2'b00, 12'h7FF, 12'h000, 0, 0, 2'b01, 12'h000, 0);
    // Parallel writes to banks 0 and 1, then read both back together.
    step(2'b11, 2'b11, 12'h010, 12'h011, 12'hABC, 12'h123, 2'b11, 0, 0);
    step(2'b11, 2'b00, 12'h010, 12'h011, 0, 0, 2'b11, 12'hABC, 12'h123);
    // Seed bank 2 with distinct data; leaves its pointer back at 0.
    step(2'b01, 2'b01, 12'h002, 12'h000, 12'h222, 0, 2'b01, 0, 0);
    step(2'b10, 2'b10, 12'h000, 12'h006, 0, 12'h666, 2'b10, 0, 0);
    // Bank 2 contention: grants alternate while inputs are held.
    step(2'b11, 2'b00, 12'h002, 12'h006, 0, 0, 2'b01, 12'h222, 0);
    step(2'b11, 2'b00, 12'h002, 12'h006, 0, 0, 2'b10, 0, 12'h666);
    step(2'b11, 2'b00, 12'h002, 12'h006, 0, 0, 2'b01, 12'h222, 0);
    step(2'b11, 2'b00, 12'h002, 12'h006, 0, 0, 2'b10, 0, 12'h666);
    // Port 1 touches bank 0 so its pointer returns to 0 before the race.
    step(2'b10, 2'b00, 12'h000, 12'h010, 0, 0, 2'b10, 0, 12'hABC);
    // Same-address race: port 0 write wins, port 1 read follows.
    step(2'b11, 2'b01, 12'h040, 12'h040, 12'h555, 0, 2'b01, 0, 0);
    step(2'b10, 2'b00, 12'h040, 12'h040, 0, 0, 2'b10, 0, 12'h555);
    step(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    chk("dout_hold_p0", 48'(dataout[11:0]), 48'h222);

    // Reset while a read is being granted: no response may follow.
    @(negedge clk);
    req = 2'b01; wr = 2'b00; address = {12'h000, 12'h010}; reset = 1'b1;
    #1;
    chk("rst_mid_gnt", 48'(gnt), 48'b01);
    do_init();
    step(2'b11, 2'b00, 12'h010, 12'h011, 0, 0, 2'b11, 12'h000, 12'h000);
    step(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);

    // Four ports all hitting bank 5 of the wider configuration.
    for (int p = 0; p < 4; p++) cnt[p] = 0;
    @(negedge clk);
    req2 = 4'hF; wr2 = 4'h0; address2 = {8'h1D, 8'h15, 8'h0D, 8'h05};
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("sweep_gnt", 48'(gnt2), 48'(4'b0001 << (k % 4)));
      for (int p = 0; p < 4; p++) if (gnt2[p]) cnt[p]++;
      @(negedge clk);
    end
    req2 = 4'h0;
    for (int p = 0; p < 4; p++) chk("sweep_count", 48'(cnt[p]), 48'd2);

    repeat (3) @(negedge clk);
    chk("sb_drained", 48'(sb.size()), 48'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
